digit_scan_ctrl: RTL
====================

Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 6-digit display; sits directly upstream of the 3-to-6 one-hot select decoder.
- Produces the decoder's 3-bit select code and enable, plus the 4-bit nibble for the active digit.
- Steps through enabled digits with a programmable dwell and a blanking gap (enable low) between digits to prevent ghosting.

Parameters:
- NUM_DIGITS, 6, number of scanned digits (2..8); select width SEL_W = $clog2(NUM_DIGITS).
- TICK_DIV, 1000, clock cycles each digit is shown (>=1).
- BLANK_CYCLES, 2, clock cycles with en low before each digit is shown (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = scanning, 0 = stop and blank.
- digit_mask  input  NUM_DIGITS  bit i = 1 means digit i is scanned.
- digits_in  input  4*NUM_DIGITS  nibble i at bits [4i+3:4i].
- sel  output  SEL_W  digit index driven to the decoder select input.
- en  output  1  decoder enable; 1 only in SHOW.
- digit_out  output  4  nibble for the current digit, latched on SHOW entry.
- frame_done  output  1  one-cycle pulse when a full pass over the enabled digits completes.

Behaviour:
- All outputs are registered. Reset (async, active-high) forces state=IDLE, sel=0, en=0, digit_out=0, frame_done=0 and clears all counters. Asserting rst mid-scan blanks immediately.
- States:
  - IDLE: en=0. On an edge with run=1 and digit_mask!=0: sel<=lowest enabled index, counter cleared, go to BLANK. Otherwise stay in IDLE.
  - BLANK: en=0, sel is stable. After BLANK_CYCLES cycles in BLANK: go to SHOW, en<=1, digit_out<=digits_in nibble[sel], counter cleared.
  - SHOW: en=1. After TICK_DIV cycles in SHOW: en<=0, sel<=next enabled index, go to BLANK.
- Next index:
  - The first index j after sel, searched cur+1 upward modulo NUM_DIGITS, with digit_mask[j]=1.
  - With a single enabled digit, next equals cur.
- frame_done:
  - Asserted for exactly one cycle, on the same edge as the SHOW->BLANK transition, when next index <= cur (wrap).
  - Never asserted in IDLE.
- Latency: from the edge sampling run=1 in IDLE, en rises after BLANK_CYCLES edges. A full cycle per digit is BLANK_CYCLES+TICK_DIV clocks.
- run=0 sampled in any state: go to IDLE on that edge, en<=0, frame_done=0; sel and digit_out hold their values.
- digit_mask changes:
  - Sampled only at IDLE exit and at SHOW->BLANK.
  - A digit masked while being shown completes its dwell.
  - If the mask is all zero at SHOW->BLANK: go to IDLE, en<=0, no frame_done.
- digits_in changes during SHOW do not affect digit_out until the next SHOW entry.
- Counter width is $clog2(max(TICK_DIV,BLANK_CYCLES)+1).
- sel never holds a value >= NUM_DIGITS.
- en=1 only in SHOW, so en is never high across a sel change.

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, BLANK, SHOW}.
  - function computing SEL_W/counter widths.
  - NIBBLE_W=4 constant.
- One natural sub-module, scan_next_sel: combinational rotating priority search (inputs cur, mask; outputs next, wrap, none).

Test Plan (TICK_DIV=4, BLANK_CYCLES=1 unless stated):
- Reset then run=1 with mask=6'b111111 and digits 0..5 = 1..6 -> sel follows 0,1,2,3,4,5,0. en is high 4 cycles, then low 1 cycle. digit_out = 1..6 in order. frame_done pulses once, at the 5->0 transition.
- mask=6'b100100 -> sel alternates 2,5,2. frame_done pulses after each digit-5 dwell. sel never takes 0,1,3,4.
- mask=6'b000001 -> sel stays 0. en pattern is 4 high / 1 low. frame_done pulses at every SHOW->BLANK edge.
- run deasserted during the 2nd SHOW cycle of digit 3 -> en=0 on that edge, state IDLE, frame_done=0. Re-assert run -> scan restarts at the lowest enabled index.
- Clear mask to 0 during SHOW of digit 1 -> digit 1 finishes its 4-cycle dwell, then IDLE, en=0, no frame_done. rst pulse mid-BLANK -> all outputs 0 asynchronously, before the next clock edge.
- Change digits_in[7:4] from 2 to 9 mid-SHOW of digit 1 -> digit_out stays 2 until the next SHOW of digit 1, which shows 9.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the digit scan controller.
//   state_t     : scan FSM states
//   NIBBLE_W    : width of one display digit code
//   idx_width   : select width for a given digit count
//   cnt_width   : width of the dwell/blank counter
package scan_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  function automatic int idx_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The counter must be able to hold the larger of the two dwell lengths.
  function automatic int cnt_width(int tick_div, int blank_cycles);
    int m;
    m = (tick_div > blank_cycles) ? tick_div : blank_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Rotating priority search for the next enabled digit.
// Ports:
//   cur  : current digit index (search starts at cur+1, modulo NUM_DIGITS)
//   mask : enabled-digit mask
//   next : first enabled index after cur (cur itself if it is the only one)
//   wrap : search went past the top index (next <= cur)
//   none : mask is all zero; next/wrap are meaningless
module scan_next_sel
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  localparam int SEL_W = idx_width(NUM_DIGITS)
) (
  input  logic [SEL_W-1:0]      cur,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      next,
  output logic                  wrap,
  output logic                  none
);

  logic                  found;
  int                    idx;
  logic [NUM_DIGITS-1:0] shifted;

  always_comb begin
    next    = cur;
    found   = 1'b0;
    idx     = 0;
    shifted = '0;
    none    = (mask == '0);
    // k runs to NUM_DIGITS so a lone enabled digit finds itself.
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      idx     = (int'(cur) + k) % NUM_DIGITS;
      shifted = mask >> idx;
      if (!found && shifted[0]) begin
        found = 1'b1;
        next  = SEL_W'(idx);
      end
    end
    wrap = found && (next <= cur);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit display. Drives the
// select code and enable of a downstream one-hot decoder, plus the nibble for
// the active digit, inserting a blanking gap between digits.
// Ports:
//   clk, rst    : clock (rising edge), async active-high reset
//   run         : 1 = scan, 0 = stop and blank
//   digit_mask  : bit i enables digit i
//   digits_in   : nibble i at [4i+3:4i]
//   sel, en     : decoder select and enable (en high only while showing)
//   digit_out   : nibble of the shown digit, captured on SHOW entry
//   frame_done  : one-cycle pulse when the scan wraps back to a lower index
//
// state | meaning
// IDLE  | not scanning, en low, sel/digit_out hold
// BLANK | en low for BLANK_CYCLES before showing the digit at sel
// SHOW  | en high for TICK_DIV cycles with digit_out latched
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  localparam int SEL_W = idx_width(NUM_DIGITS),
  localparam int CNT_W = cnt_width(TICK_DIV, BLANK_CYCLES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  input  logic [NUM_DIGITS-1:0]          digit_mask,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
  output logic [SEL_W-1:0]               sel,
  output logic                           en,
  output logic [NIBBLE_W-1:0]            digit_out,
  output logic                           frame_done
);

  state_t                         state, state_d;
  logic [CNT_W-1:0]               cnt, cnt_d;
  logic [SEL_W-1:0]               sel_d, search_cur, next_sel;
  logic                           en_d, frame_done_d, wrap, none;
  logic [NIBBLE_W-1:0]            digit_d;
  logic [NIBBLE_W*NUM_DIGITS-1:0] nib_shifted;

  // From IDLE the search starts just past the top index, which yields the
  // lowest enabled digit; afterwards it starts from the current digit.
  assign search_cur = (state == IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel;

  scan_next_sel #(.NUM_DIGITS(NUM_DIGITS)) u_next_sel (
    .cur  (search_cur),
    .mask (digit_mask),
    .next (next_sel),
    .wrap (wrap),
    .none (none)
  );

  assign nib_shifted = digits_in >> (NIBBLE_W * int'(sel));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      en         <= 1'b0;
      digit_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sel        <= sel_d;
      en         <= en_d;
      digit_out  <= digit_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    sel_d        = sel;
    en_d         = 1'b0;
    digit_d      = digit_out;
    frame_done_d = 1'b0;
    if (!run) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!none) begin
            sel_d   = next_sel;
            cnt_d   = '0;
            state_d = BLANK;
          end
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            en_d    = 1'b1;
            digit_d = nib_shifted[NIBBLE_W-1:0];
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        SHOW: begin
          en_d = 1'b1;
          if (cnt == CNT_W'(TICK_DIV - 1)) begin
            en_d  = 1'b0;
            cnt_d = '0;
            // Mask is only consulted here, so a digit masked mid-dwell
            // still finishes its full dwell.
            if (none) begin
              state_d = IDLE;
            end else begin
              sel_d        = next_sel;
              state_d      = BLANK;
              frame_done_d = wrap;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule
